ustream_accum: RTL and testbench

USTREAM_ACCUM -- requirements
Module: ustream_accum

---
 rtl/ustream_accum.sv | 132 +++++++++++++
 tb/tb_ustream_accum.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ustream_accum.sv
// ustream_accum: counts the ones in a fixed window of 2^(BW+1) valid bits of a
// unary bitstream. An optional warm-up drops the first WARMUP valid bits after
// start. The result is then held until the consumer completes the handshake.
module ustream_accum #(
    parameter int unsigned BW     = 5,
    parameter int unsigned WARMUP = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic          in,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW+1:0] out
);

    localparam int unsigned AccW  = BW + 2;
    localparam int unsigned CntW  = BW + 1;
    localparam int unsigned WarmW = 16;
    // Index of the last warm-up bit; unused when WARMUP is zero.
    localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP - 1);

    typedef enum logic [1:0] {StIdle, StWarm, StAcc, StHold} state_e;

    state_e            state_q, state_d;
    logic [WarmW-1:0]  warm_q, warm_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   acc_q, acc_d;

    logic warm_last;
    logic cnt_last;

    assign warm_last = (warm_q == WarmLast);
    // All-ones sample counter means this valid bit closes the window.
    assign cnt_last  = &cnt_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (WARMUP > 0) ? StWarm : StAcc;
                end
            end
            StWarm: begin
                if (in_valid && warm_last) begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (in_valid && cnt_last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter and accumulator next values; all cleared when a start is accepted.
    always_comb begin
        warm_d = warm_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    warm_d = '0;
                    cnt_d  = '0;
                    acc_d  = '0;
                end
            end
            StWarm: begin
                if (in_valid) begin
                    warm_d = warm_q + WarmW'(1);
                end
            end
            StAcc: begin
                if (in_valid) begin
                    // Wraps to zero on the window-closing bit.
                    cnt_d = cnt_q + CntW'(1);
                    acc_d = acc_q + AccW'(in);
                end
            end
            StHold: begin
                // Result frozen until the handshake.
            end
            default: begin
                warm_d = '0;
                cnt_d  = '0;
                acc_d  = '0;
            end
        endcase
    end

    // Counter and accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            warm_q <= warm_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    // Outputs decoded from registered state; out shows the live accumulator.
    always_comb begin
        busy      = (state_q == StWarm) || (state_q == StAcc);
        out_valid = (state_q == StHold);
        out       = acc_q;
    end

endmodule

// File: tb/tb_ustream_accum.sv
// Directed bench for ustream_accum: one instance with no warm-up, one with a
// warm-up of four bits, sharing clock and stimulus.
module tb_ustream_accum;

    localparam int BW = 5;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic            in;
    logic            out_ready;
    logic            busy0, ov0, busy4, ov4;
    logic [BW+1:0]   out0, out4;

    int nchk;
    int nerr;
    int both_cnt;

    typedef struct {
        int warm_sel;  // 0: WARMUP=0 instance, 1: WARMUP=4 instance
        int pat;       // bit pattern over valid-bit index
        int vgap;      // 0: in_valid always 1, 1: in_valid 0,1,0,1...
        int exp_out;
        int exp_lat;   // cycles from start cycle to first out_valid cycle
    } vec_t;

    vec_t vecs[7];

    ustream_accum #(.BW(BW), .WARMUP(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in        (in),
        .busy      (busy0),
        .out_valid (ov0),
        .out_ready (out_ready),
        .out       (out0)
    );

    ustream_accum #(.BW(BW), .WARMUP(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in        (in),
        .busy      (busy4),
        .out_valid (ov4),
        .out_ready (out_ready),
        .out       (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((busy0 && ov0) || (busy4 && ov4)) both_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic pat_bit(input int pat, input int k);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k % 2) == 0;
            3:       return k < 20;
            4:       return (k < 4) ? 1'b1 : ((k - 4) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one conversion; optionally completes the handshake afterwards.
    task automatic run_vec(input vec_t v, input int id, input bit do_rst, input bit do_hs);
        int  cyc;
        int  vidx;
        int  lat;
        logic sv, sb;
        logic [BW+1:0] so;
        if (do_rst) do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 1;
        vidx = 0;
        lat  = -1;
        while (cyc <= 400 && lat < 0) begin
            sv = v.warm_sel ? ov4 : ov0;
            if (sv) begin
                lat = cyc;
            end else begin
                in_valid = (v.vgap == 0) ? 1'b1 : ((cyc % 2) == 0);
                if (in_valid) begin
                    in = pat_bit(v.pat, vidx);
                    vidx++;
                end else begin
                    in = 1'b1;  // must be ignored
                end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        in       = 1'b0;
        so = v.warm_sel ? out4 : out0;
        sb = v.warm_sel ? busy4 : busy0;
        chk($sformatf("vec%0d_latency", id), lat, v.exp_lat);
        chk($sformatf("vec%0d_out", id), int'(so), v.exp_out);
        chk($sformatf("vec%0d_busy_in_hold", id), int'(sb), 0);
        if (do_hs) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            sv = v.warm_sel ? ov4 : ov0;
            chk($sformatf("vec%0d_valid_after_hs", id), int'(sv), 0);
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        both_cnt = 0;

        vecs[0] = '{warm_sel: 0, pat: 1, vgap: 0, exp_out: 64, exp_lat: 65};
        vecs[1] = '{warm_sel: 1, pat: 4, vgap: 0, exp_out: 32, exp_lat: 69};
        vecs[2] = '{warm_sel: 0, pat: 1, vgap: 1, exp_out: 64, exp_lat: 129};
        vecs[3] = '{warm_sel: 0, pat: 0, vgap: 0, exp_out: 0,  exp_lat: 65};
        vecs[4] = '{warm_sel: 0, pat: 3, vgap: 0, exp_out: 20, exp_lat: 65};
        vecs[5] = '{warm_sel: 1, pat: 1, vgap: 1, exp_out: 64, exp_lat: 137};
        vecs[6] = '{warm_sel: 0, pat: 2, vgap: 1, exp_out: 32, exp_lat: 129};

        // Reset state
        do_reset();
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_valid0", int'(ov0), 0);
        chk("rst_out0", int'(out0), 0);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_valid4", int'(ov4), 0);
        chk("rst_out4", int'(out4), 0);

        // Idle ignores in/in_valid without start
        in_valid = 1'b1;
        in       = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        in       = 1'b0;
        chk("idle_ignore_busy", int'(busy0), 0);
        chk("idle_ignore_out", int'(out0), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i, 1'b1, 1'b1);
        end

        // Hold without ready, start pulses ignored, then handshake and restart
        run_vec(vecs[0], 10, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3 || i == 6);
            @(negedge clk);
            chk($sformatf("hold%0d_valid", i), int'(ov0), 1);
            chk($sformatf("hold%0d_out", i), int'(out0), 64);
        end
        out_ready = 1'b1;
        start     = 1'b1;  // coincides with handshake, must not be honoured
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hs_valid_low", int'(ov0), 0);
        chk("hs_start_ignored", int'(busy0), 0);
        @(negedge clk);
        chk("idle_not_queued", int'(busy0), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", int'(busy0), 1);

        // Reset on the 30th valid ACC bit, then a fresh full window
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 30; c++) begin
            in_valid = 1'b1;
            in       = 1'b1;
            @(negedge clk);
        end
        chk("live_acc_29", int'(out0), 29);
        in_valid = 1'b1;
        in       = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in       = 1'b0;
        chk("midacc_rst_busy", int'(busy0), 0);
        chk("midacc_rst_valid", int'(ov0), 0);
        chk("midacc_rst_out", int'(out0), 0);
        rst_n = 1'b1;
        run_vec(vecs[0], 11, 1'b0, 1'b1);

        // Reset in HOLD has priority over start and out_ready
        run_vec(vecs[4], 12, 1'b1, 1'b0);
        rst_n     = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("hold_rst_valid", int'(ov0), 0);
        chk("hold_rst_busy", int'(busy0), 0);
        chk("hold_rst_out", int'(out0), 0);
        @(negedge clk);
        chk("hold_rst_stays_idle", int'(busy0), 0);

        chk("never_busy_and_valid", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
